// File: rtl/idli_pkg.sv
// Shared types and constants for the idli fetch stage.
package idli_pkg;

    localparam int FE_DEPTH_DFLT = 2;

    // One buffered instruction together with the word address it came from.
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc;
    } fe_entry_t;

    // Select nibble idx of a 16b word; execute walks words nibble-serially.
    function automatic logic [3:0] nib_sel(input logic [15:0] w, input logic [1:0] idx);
        return w[{idx, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/idli_fetch_if.sv
// Fetch-stage bus bundle: SQI memory side, decode side and execute side.
interface idli_fetch_if;

    logic [3:0]  i_fe_mem_data;
    logic        i_fe_mem_vld;
    logic        o_fe_mem_rdy;
    logic        o_fe_mem_restart;
    logic [15:0] o_fe_mem_addr;
    logic [15:0] o_fe_instr;
    logic        o_fe_instr_vld;
    logic        i_fe_instr_acp;
    logic [1:0]  i_fe_ctr;
    logic [3:0]  o_fe_pc;
    logic [3:0]  o_fe_pc_next;
    logic        i_fe_redirect;
    logic [3:0]  i_fe_redirect_pc;

    // Fetch stage side.
    modport master (
        input  i_fe_mem_data, i_fe_mem_vld, i_fe_instr_acp,
        input  i_fe_ctr, i_fe_redirect, i_fe_redirect_pc,
        output o_fe_mem_rdy, o_fe_mem_restart, o_fe_mem_addr,
        output o_fe_instr, o_fe_instr_vld, o_fe_pc, o_fe_pc_next
    );

    // Memory / decode / execute side.
    modport slave (
        output i_fe_mem_data, i_fe_mem_vld, i_fe_instr_acp,
        output i_fe_ctr, i_fe_redirect, i_fe_redirect_pc,
        input  o_fe_mem_rdy, o_fe_mem_restart, o_fe_mem_addr,
        input  o_fe_instr, o_fe_instr_vld, o_fe_pc, o_fe_pc_next
    );

endinterface

// File: rtl/idli_fetch_fifo_m.sv
// Small instruction FIFO between nibble assembly and decode.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The caller only pushes when not full (or popping) and pops when not empty.
module idli_fetch_fifo_m
    import idli_pkg::*;
#(
    parameter int DEPTH = FE_DEPTH_DFLT
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  fe_entry_t wdata,
    input  logic      pop,
    input  logic      flush,
    output fe_entry_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    fe_entry_t     mem_q [DEPTH];

    // Pointer update; flush empties the FIFO and overrides push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
        end
    end

    // Entry storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/idli_fetch_m.sv
// Fetch stage: assembles SQI nibbles into 16b words tagged with their PC,
// buffers them for decode, serves PC nibbles to execute and absorbs
// execute redirects by flushing and restarting the memory stream.
module idli_fetch_m
    import idli_pkg::*;
#(
    parameter int DEPTH = FE_DEPTH_DFLT
) (
    input  logic         i_fe_gck,
    input  logic         i_ex_rst_n,
    idli_fetch_if.master fe
);

    logic [1:0]  nib_q;
    logic [11:0] asm_q;
    logic [15:0] fetch_pc_q;
    logic        restart_q;

    logic        full;
    logic        empty;
    logic        pop;
    logic        accept;
    logic        push;
    fe_entry_t   entry;
    fe_entry_t   head;

    // A redirect hides the FIFO immediately even though the flush lands at the edge.
    assign fe.o_fe_instr_vld   = !empty && !fe.i_fe_redirect;
    assign pop                 = fe.i_fe_instr_acp && fe.o_fe_instr_vld;

    // The last nibble of a word may only land if there is room, counting a same-cycle pop.
    assign fe.o_fe_mem_rdy     = !fe.i_fe_redirect && !restart_q &&
                                 !((nib_q == 2'd3) && full && !pop);
    assign accept              = fe.i_fe_mem_vld && fe.o_fe_mem_rdy;
    assign push                = accept && (nib_q == 2'd3);
    assign entry               = '{instr: {fe.i_fe_mem_data, asm_q}, pc: fetch_pc_q};

    // Restart is held back while a redirect is still writing the PC.
    assign fe.o_fe_mem_restart = restart_q && !fe.i_fe_redirect;
    assign fe.o_fe_mem_addr    = fetch_pc_q;

    assign fe.o_fe_instr       = head.instr;
    assign fe.o_fe_pc          = nib_sel(head.pc, fe.i_fe_ctr);
    assign fe.o_fe_pc_next     = nib_sel(head.pc + 16'd1, fe.i_fe_ctr);

    // Nibble position, fetch PC and restart request; redirect has priority over streaming.
    always_ff @(posedge i_fe_gck or negedge i_ex_rst_n) begin
        if (!i_ex_rst_n) begin
            nib_q      <= 2'd0;
            fetch_pc_q <= 16'd0;
            restart_q  <= 1'b1;
        end else if (fe.i_fe_redirect) begin
            nib_q <= 2'd0;
            fetch_pc_q[{fe.i_fe_ctr, 2'b00} +: 4] <= fe.i_fe_redirect_pc;
            if (fe.i_fe_ctr == 2'd3) restart_q <= 1'b1;
        end else begin
            restart_q <= 1'b0;
            if (accept) nib_q      <= nib_q + 2'd1;
            if (push)   fetch_pc_q <= fetch_pc_q + 16'd1;
        end
    end

    // Lower three nibbles of the word in flight; the top nibble goes straight into the FIFO.
    always_ff @(posedge i_fe_gck) begin
        if (accept && (nib_q != 2'd3)) asm_q[{nib_q, 2'b00} +: 4] <= fe.i_fe_mem_data;
    end

    idli_fetch_fifo_m #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (i_fe_gck),
        .rst_n (i_ex_rst_n),
        .push  (push),
        .wdata (entry),
        .pop   (pop),
        .flush (fe.i_fe_redirect),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

endmodule

// File: tb/tb_idli_fetch_m.sv
// Scoreboard bench for idli_fetch_m: stimulus pushes expected words and
// restart addresses, monitors pop and compare on the falling edge.
module tb_idli_fetch_m;
    import idli_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    idli_fetch_if fe_if ();

    idli_fetch_m #(.DEPTH(2)) dut (
        .i_fe_gck   (clk),
        .i_ex_rst_n (rst_n),
        .fe         (fe_if)
    );

    int          errors = 0;
    int          checks = 0;
    fe_entry_t   exp_q[$];
    logic [15:0] rst_q[$];
    fe_entry_t   mon_e;
    logic [15:0] mon_a;

    function automatic logic [3:0] nib(input logic [15:0] w, input logic [1:0] i);
        return w[{i, 2'b00} +: 4];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop/compare instruction words and restart pulses.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (fe_if.o_fe_instr_vld && fe_if.i_fe_instr_acp) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL pop_unexpected: got instr %h expected no word", fe_if.o_fe_instr);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("pop_instr", {16'h0, fe_if.o_fe_instr}, {16'h0, mon_e.instr});
                    chk("pop_pc_nib", {28'h0, fe_if.o_fe_pc}, {28'h0, nib(mon_e.pc, fe_if.i_fe_ctr)});
                    chk("pop_pcnext_nib", {28'h0, fe_if.o_fe_pc_next},
                        {28'h0, nib(mon_e.pc + 16'd1, fe_if.i_fe_ctr)});
                end
            end
            if (fe_if.o_fe_mem_restart) begin
                if (rst_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL restart_unexpected: got addr %h expected no pulse", fe_if.o_fe_mem_addr);
                end else begin
                    mon_a = rst_q.pop_front();
                    chk("restart_addr", {16'h0, fe_if.o_fe_mem_addr}, {16'h0, mon_a});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        fe_if.i_fe_ctr = fe_if.i_fe_ctr + 2'd1;
    endtask

    task automatic send_nib(input logic [3:0] d);
        bit ok;
        ok = 1'b0;
        fe_if.i_fe_mem_data = d;
        fe_if.i_fe_mem_vld  = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = fe_if.o_fe_mem_rdy;
            tick();
        end
        fe_if.i_fe_mem_vld = 1'b0;
        if (!ok) begin
            checks++; errors++;
            $display("FAIL nib_timeout: rdy got 0 expected 1");
        end
    endtask

    task automatic send_word(input logic [15:0] w, input logic [15:0] pc);
        for (int k = 0; k < 4; k++) send_nib(w[4*k +: 4]);
        exp_q.push_back('{instr: w, pc: pc});
    endtask

    task automatic drain();
        fe_if.i_fe_instr_acp = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        fe_if.i_fe_instr_acp = 1'b0;
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        while (fe_if.i_fe_ctr != 2'd0) tick();
        exp_q.delete();
        rst_q.push_back(pc);
        fe_if.i_fe_redirect = 1'b1;
        for (int i = 0; i < 4; i++) begin
            fe_if.i_fe_redirect_pc = pc[{fe_if.i_fe_ctr, 2'b00} +: 4];
            @(negedge clk);
            if (i == 0) chk("redir_vld", fe_if.o_fe_instr_vld, 0);
            chk("redir_rdy", fe_if.o_fe_mem_rdy, 0);
            tick();
        end
        fe_if.i_fe_redirect    = 1'b0;
        fe_if.i_fe_redirect_pc = 4'h0;
        @(negedge clk);
        chk("pulse_rdy", fe_if.o_fe_mem_rdy, 0);
        chk("pulse_vld", fe_if.o_fe_instr_vld, 0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n                  = 1'b0;
        fe_if.i_fe_mem_data    = 4'h0;
        fe_if.i_fe_mem_vld     = 1'b0;
        fe_if.i_fe_instr_acp   = 1'b0;
        fe_if.i_fe_ctr         = 2'd0;
        fe_if.i_fe_redirect    = 1'b0;
        fe_if.i_fe_redirect_pc = 4'h0;

        // 1. reset state, first word after release
        tick(); tick();
        chk("rst_vld", fe_if.o_fe_instr_vld, 0);
        chk("rst_rdy", fe_if.o_fe_mem_rdy, 0);
        chk("rst_restart", fe_if.o_fe_mem_restart, 1);
        chk("rst_addr", fe_if.o_fe_mem_addr, 0);
        rst_q.push_back(16'h0000);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_pulse_rdy", fe_if.o_fe_mem_rdy, 0);
        tick();
        send_word(16'h1234, 16'h0000);
        @(negedge clk);
        chk("latency_vld", fe_if.o_fe_instr_vld, 1);
        chk("t1_instr", fe_if.o_fe_instr, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_pc", fe_if.o_fe_pc, 0);
            chk("t1_pcnext", fe_if.o_fe_pc_next, (fe_if.i_fe_ctr == 2'd0) ? 1 : 0);
            tick();
        end
        drain();

        // 2. fill FIFO, third word's last nibble held until a pop
        send_word(16'hA001, 16'h0001);
        send_word(16'hA002, 16'h0002);
        send_nib(4'h3); send_nib(4'h0); send_nib(4'h0);
        fe_if.i_fe_mem_data = 4'hA;
        fe_if.i_fe_mem_vld  = 1'b1;
        @(negedge clk);
        chk("full_hold_rdy", fe_if.o_fe_mem_rdy, 0);
        tick();
        @(negedge clk);
        chk("full_hold_rdy2", fe_if.o_fe_mem_rdy, 0);
        chk("full_head", fe_if.o_fe_instr, 16'hA001);
        tick();
        fe_if.i_fe_instr_acp = 1'b1;
        @(negedge clk);
        chk("pop_unblocks_rdy", fe_if.o_fe_mem_rdy, 1);
        tick();
        fe_if.i_fe_instr_acp = 1'b0;
        fe_if.i_fe_mem_vld   = 1'b0;
        exp_q.push_back('{instr: 16'hA003, pc: 16'h0003});
        drain();

        // 3. redirect to 0xBEEF with FIFO full
        send_word(16'h5A5A, 16'h0004);
        send_word(16'h6B6B, 16'h0005);
        redirect_to(16'hBEEF);
        @(negedge clk);
        chk("post_pulse_rdy", fe_if.o_fe_mem_rdy, 1);
        tick();
        send_word(16'hC0DE, 16'hBEEF);
        drain();

        // 4. PC wrap
        redirect_to(16'hFFFF);
        send_word(16'h1111, 16'hFFFF);
        send_word(16'h2222, 16'h0000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wrap_pc", fe_if.o_fe_pc, 4'hF);
            chk("wrap_pcnext", fe_if.o_fe_pc_next, 4'h0);
            tick();
        end
        drain();

        // 5. nibble presented mid-word and during the redirect is dropped
        send_nib(4'h1);
        send_nib(4'h2);
        fe_if.i_fe_mem_data = 4'hF;
        fe_if.i_fe_mem_vld  = 1'b1;
        redirect_to(16'h1357);
        fe_if.i_fe_mem_vld  = 1'b0;
        send_word(16'h4321, 16'h1357);
        drain();

        // 6. async reset mid-word with one buffered entry
        send_word(16'h7777, 16'h1358);
        send_nib(4'h8);
        send_nib(4'h9);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_vld", fe_if.o_fe_instr_vld, 0);
        chk("arst_rdy", fe_if.o_fe_mem_rdy, 0);
        chk("arst_restart", fe_if.o_fe_mem_restart, 1);
        chk("arst_addr", fe_if.o_fe_mem_addr, 0);
        exp_q.delete();
        rst_q.delete();
        rst_q.push_back(16'h0000);
        tick(); tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("arst_no_stale", fe_if.o_fe_instr_vld, 0);
        tick();
        send_word(16'h2468, 16'h0000);
        drain();

        tick(); tick();
        chk("restart_left", rst_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
